// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, datapath widths, the bubble
// instruction, the default reset PC, the opcode field position and the
// IF/ID register payload.
package if_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    // Fetch FSM encoding
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OP_FIELD_HI = 31;
    localparam int unsigned OP_FIELD_LO = 26;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read channel (req/ack handshake).
//   IMemReq   : read request, held until IMemAck
//   IMemAddr  : word-aligned read address, stable while waiting
//   IMemAck   : data returned this cycle
//   IMemRData : instruction word, valid with IMemAck
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_unit_if;
    import if_pkg::*;

    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemAck;
    logic [XLEN-1:0] IMemRData;

    modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemRData);
    modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemRData);

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds instruction, PC+4 and valid.
//   clk, rst : clock and asynchronous active-high reset
//   enable   : load d into the register
//   flush    : insert a bubble (NOP, valid=0); wins over enable
//   d, q     : next / current register contents
module if_id_register
    import if_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{instruction: NOP_WORD, pc_plus4: XLEN'(0), valid: 1'b0};
        end else if (flush) begin
            q.instruction <= NOP_WORD;
            q.valid       <= 1'b0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline.
// Keeps the PC, issues word reads to instruction memory, loads the IF/ID
// register and exposes the opcode field to the main decoder. Handles decode
// stall (with a one-word skid buffer) and branch/jump redirect.
//   Clk, Reset     : clock, asynchronous active-high reset
//   Stall          : decode hazard, IF/ID and PC hold
//   BranchTaken    : redirect pulse from EX, BranchTarget is its address
//   imem           : instruction memory read channel (master side)
//   IF_Instruction, IF_PCPlus4, IF_Valid : IF/ID register
//   Op             : opcode field of IF_Instruction, combinational
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Stall,
    input  logic                        BranchTaken,
    input  logic [XLEN-1:0]             BranchTarget,
    instruction_fetch_unit_if.master    imem,
    output logic [XLEN-1:0]             IF_Instruction,
    output logic [XLEN-1:0]             IF_PCPlus4,
    output logic                        IF_Valid,
    output logic [OP_W-1:0]             Op
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic            req_q, req_d;

    logic            if_en;
    logic            if_flush;
    if_id_t          if_d;
    if_id_t          if_q;

    logic            ack;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_seq;

    // An ack is only meaningful while a request is outstanding.
    assign ack      = imem.IMemAck & req_q;
    assign target   = align_word(BranchTarget);
    assign next_seq = req_addr_q + XLEN'(4);

    // State and fetch-address registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_START;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            skid_q     <= XLEN'(0);
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            skid_q     <= skid_d;
            req_q      <= req_d;
        end
    end

    // Next-state, datapath and IF/ID control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        skid_d     = skid_q;
        if_en      = 1'b0;
        if_flush   = 1'b0;
        if_d       = if_q;

        case (state_q)
            ST_START: begin
                if (BranchTaken) begin
                    pc_d       = target;
                    req_addr_d = target;
                end
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (BranchTaken) begin
                    pc_d     = target;
                    if_flush = 1'b1;
                    if (ack) begin
                        req_addr_d = target;
                    end else begin
                        // The in-flight read must finish before redirecting.
                        state_d = ST_DRAIN;
                    end
                end else if (ack) begin
                    if (Stall) begin
                        skid_d  = imem.IMemRData;
                        state_d = ST_HOLD;
                    end else begin
                        if_en      = 1'b1;
                        if_d       = '{instruction: imem.IMemRData, pc_plus4: next_seq, valid: 1'b1};
                        pc_d       = next_seq;
                        req_addr_d = next_seq;
                    end
                end else if (!Stall) begin
                    // Decode consumed the current word; nothing new arrived.
                    if_en      = 1'b1;
                    if_d.valid = 1'b0;
                end
            end

            ST_HOLD: begin
                if (BranchTaken) begin
                    pc_d       = target;
                    req_addr_d = target;
                    if_flush   = 1'b1;
                    state_d    = ST_FETCH;
                end else if (!Stall) begin
                    if_en      = 1'b1;
                    if_d       = '{instruction: skid_q, pc_plus4: next_seq, valid: 1'b1};
                    pc_d       = next_seq;
                    req_addr_d = next_seq;
                    state_d    = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                if (BranchTaken) begin
                    pc_d = target;
                end
                if (ack) begin
                    // Returned word belongs to the squashed path; drop it.
                    req_addr_d = BranchTaken ? target : pc_q;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase

        req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    if_id_register u_if_id (
        .clk    (Clk),
        .rst    (Reset),
        .enable (if_en),
        .flush  (if_flush),
        .d      (if_d),
        .q      (if_q)
    );

    assign imem.IMemReq  = req_q;
    assign imem.IMemAddr = req_addr_q;

    assign IF_Instruction = if_q.instruction;
    assign IF_PCPlus4     = if_q.pc_plus4;
    assign IF_Valid       = if_q.valid;
    assign Op             = if_q.instruction[OP_FIELD_HI:OP_FIELD_LO];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver pushes expected
// memory addresses and decoded instructions; a negedge monitor pops and
// compares on every memory handshake and every instruction consumed by decode.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic [5:0]  Op;

    logic        stall2;
    logic        br2;
    logic [31:0] tgt2;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;
    logic [5:0]  op2;

    logic        mem_on;
    int          lat;
    int          cnt;

    int          errors;
    int          checks;

    logic [31:0] exp_addr[$];
    exp_t        exp_instr[$];

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus2 ();

    instruction_fetch_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .imem           (bus),
        .IF_Instruction (IF_Instruction),
        .IF_PCPlus4     (IF_PCPlus4),
        .IF_Valid       (IF_Valid),
        .Op             (Op)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (stall2),
        .BranchTaken    (br2),
        .BranchTarget   (tgt2),
        .imem           (bus2),
        .IF_Instruction (instr2),
        .IF_PCPlus4     (pc4_2),
        .IF_Valid       (valid2),
        .Op             (op2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0008: return 32'h8C22_0004;
            default:       return 32'h2000_0000 | a;
        endcase
    endfunction

    // Memory model for dut: acks after 'lat' waiting cycles
    always_comb begin
        bus.IMemAck   = bus.IMemReq && mem_on && (cnt == lat);
        bus.IMemRData = bus.IMemAck ? mem_word(bus.IMemAddr) : 32'hDEAD_BEEF;
    end

    always @(posedge Clk or posedge Reset) begin
        if (Reset)                             cnt <= 0;
        else if (!bus.IMemReq || bus.IMemAck)  cnt <= 0;
        else                                   cnt <= cnt + 1;
    end

    // Zero-wait memory returning all-zero words for dut2
    assign bus2.IMemAck   = bus2.IMemReq;
    assign bus2.IMemRData = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_i(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.pc4   = p;
        exp_instr.push_back(e);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        check({tag, "_instr_left"}, 32'(exp_instr.size()), 32'd0);
        exp_addr.delete();
        exp_instr.delete();
    endtask

    // Monitor: memory handshakes and instructions consumed by decode
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.IMemReq && bus.IMemAck) begin
                if (exp_addr.size() == 0) begin
                    check("addr_unexpected", bus.IMemAddr, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addr.pop_front();
                    check("imem_addr", bus.IMemAddr, ea);
                end
            end
            if (IF_Valid && !Stall && !BranchTaken) begin
                if (exp_instr.size() == 0) begin
                    check("instr_unexpected", IF_Instruction, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_instr.pop_front();
                    check("if_instruction", IF_Instruction, e.instr);
                    check("if_pcplus4", IF_PCPlus4, e.pc4);
                    check("op", 32'(Op), 32'(e.instr[31:26]));
                end
            end
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        Reset        = 1'b1;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        stall2       = 1'b0;
        br2          = 1'b0;
        tgt2         = 32'h0;
        mem_on       = 1'b1;
        lat          = 0;

        // Reset state
        repeat (2) tick();
        check("rst_req", 32'(bus.IMemReq), 32'd0);
        check("rst_addr", bus.IMemAddr, 32'h0);
        check("rst_instr", IF_Instruction, 32'h0);
        check("rst_pc4", IF_PCPlus4, 32'h0);
        check("rst_valid", 32'(IF_Valid), 32'd0);
        check("rst_op", 32'(Op), 32'd0);
        check("rst2_addr", bus2.IMemAddr, 32'hFFFF_FFF8);

        // A: zero-wait stream, stall with skid, redirects with ack
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
                     32'h40, 32'h44, 32'h48, 32'h40};
        push_i(32'h2000_0000, 32'h4);
        push_i(32'h2000_0004, 32'h8);
        push_i(32'h8C22_0004, 32'hC);
        push_i(32'h2000_000C, 32'h10);
        push_i(32'h2000_0010, 32'h14);
        push_i(32'h2000_0040, 32'h44);
        push_i(32'h2000_0040, 32'h44);
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            Stall        = (k >= 5 && k <= 7) || (k == 13);
            BranchTaken  = (k == 10) || (k == 13);
            BranchTarget = 32'h43;
            mem_on       = (k < 15);
            @(negedge Clk);
            if (k == 4) begin
                check("a_lw_instr", IF_Instruction, 32'h8C22_0004);
                check("a_lw_op", 32'(Op), 32'h23);
                check("a_lw_pc4", IF_PCPlus4, 32'hC);
            end
            if (k == 6 || k == 7) begin
                check("a_stall_req", 32'(bus.IMemReq), 32'd0);
                check("a_stall_instr", IF_Instruction, 32'h2000_000C);
                check("a_stall_pc4", IF_PCPlus4, 32'h10);
                check("a_stall_valid", 32'(IF_Valid), 32'd1);
            end
            if (k == 11 || k == 14) begin
                check("a_br_valid", 32'(IF_Valid), 32'd0);
                check("a_br_instr", IF_Instruction, 32'h0);
                check("a_br_addr", bus.IMemAddr, 32'h40);
            end
            if (k == 16 || k == 17) begin
                check("a_noack_valid", 32'(IF_Valid), 32'd0);
                check("a_noack_req", 32'(bus.IMemReq), 32'd1);
                check("a_noack_addr", bus.IMemAddr, 32'h44);
            end
        end
        queues_empty("a");

        // B: two-cycle memory, redirect while a read is in flight
        Reset        = 1'b1;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        mem_on       = 1'b1;
        lat          = 2;
        repeat (2) tick();
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
                     32'h1C, 32'h20, 32'h100};
        push_i(32'h2000_0000, 32'h4);
        push_i(32'h2000_0004, 32'h8);
        push_i(32'h8C22_0004, 32'hC);
        push_i(32'h2000_000C, 32'h10);
        push_i(32'h2000_0010, 32'h14);
        push_i(32'h2000_0014, 32'h18);
        push_i(32'h2000_0018, 32'h1C);
        push_i(32'h2000_0100, 32'h104);
        Reset = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            BranchTaken  = (k == 25);
            BranchTarget = 32'h100;
            mem_on       = (k < 31);
            @(negedge Clk);
            if (k == 5) check("b_bubble_valid", 32'(IF_Valid), 32'd0);
            if (k == 26 || k == 27) begin
                check("b_drain_addr", bus.IMemAddr, 32'h20);
                check("b_drain_req", 32'(bus.IMemReq), 32'd1);
                check("b_drain_valid", 32'(IF_Valid), 32'd0);
            end
            if (k == 28) check("b_redirect_addr", bus.IMemAddr, 32'h100);
        end
        queues_empty("b");

        // C: wrap-around PC on dut2, then reset mid-run
        Reset       = 1'b1;
        BranchTaken = 1'b0;
        mem_on      = 1'b1;
        lat         = 0;
        repeat (2) tick();
        exp_addr = '{32'h0, 32'h4, 32'h8};
        push_i(32'h2000_0000, 32'h4);
        push_i(32'h2000_0004, 32'h8);
        Reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge Clk);
            if (k == 1) begin
                check("c_wrap_addr1", bus2.IMemAddr, 32'hFFFF_FFF8);
                check("c_wrap_req1", 32'(bus2.IMemReq), 32'd1);
            end
            if (k == 2) begin
                check("c_wrap_addr2", bus2.IMemAddr, 32'hFFFF_FFFC);
                check("c_wrap_pc4_2", pc4_2, 32'hFFFF_FFFC);
                check("c_wrap_valid2", 32'(valid2), 32'd1);
                check("c_wrap_instr2", instr2, 32'h0);
                check("c_wrap_op2", 32'(op2), 32'd0);
            end
            if (k == 3) begin
                check("c_wrap_addr3", bus2.IMemAddr, 32'h0000_0000);
                check("c_wrap_pc4_3", pc4_2, 32'h0000_0000);
            end
        end
        #2;
        Reset = 1'b1;
        #1;
        check("c_mid_req", 32'(bus.IMemReq), 32'd0);
        check("c_mid_addr", bus.IMemAddr, 32'h0);
        check("c_mid_instr", IF_Instruction, 32'h0);
        check("c_mid_pc4", IF_PCPlus4, 32'h0);
        check("c_mid_valid", 32'(IF_Valid), 32'd0);
        check("c_mid_op", 32'(Op), 32'd0);
        check("c_mid_addr2", bus2.IMemAddr, 32'hFFFF_FFF8);
        queues_empty("c");

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
